// File: rtl/sdp_ram_fifo_ctrl_if.sv
// Ready/valid stream bundle for sdp_ram_fifo_ctrl: producer push side and consumer pop side.
// The controller takes the slave view; the producer/consumer pair takes the master view.
interface sdp_ram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  push_ready;
  logic                  pop_valid;
  logic [DATA_WIDTH-1:0] pop_data;
  logic                  pop;

  modport master (
    output push, push_data, pop,
    input  push_ready, pop_valid, pop_data
  );

  modport slave (
    input  push, push_data, pop,
    output push_ready, pop_valid, pop_data
  );
endinterface

// File: rtl/sdp_ram_fifo_ctrl.sv
// FIFO controller wrapping an external simple-dual-port RAM, with a skid buffer behind the read pipeline.
// Optional occupancy output enabled by defining SDP_RAM_FIFO_COUNT_EN.
module sdp_ram_fifo_ctrl #(
  parameter  int ADDR_WIDTH   = 10,
  parameter  int NUM_COL      = 4,
  parameter  int COL_WIDTH    = 8,
  parameter  int READ_LATENCY = 2,
  localparam int DATA_WIDTH   = NUM_COL * COL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  sdp_ram_fifo_ctrl_if.slave    fifo,
  output logic                  ram_a_en,
  output logic [NUM_COL-1:0]    ram_a_wbe,
  output logic [DATA_WIDTH-1:0] ram_a_wdata,
  output logic [ADDR_WIDTH-1:0] ram_a_addr,
  output logic                  ram_b_en,
  output logic [ADDR_WIDTH-1:0] ram_b_addr,
  input  logic [DATA_WIDTH-1:0] ram_b_rdata
`ifdef SDP_RAM_FIFO_COUNT_EN
  ,
  output logic [ADDR_WIDTH+1:0] occupancy
`endif
);

  localparam int SKID_DEPTH = READ_LATENCY + 1;
  localparam int SKID_AW    = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int SCW        = $clog2(SKID_DEPTH + 1);
  localparam int CRW        = $clog2(2 * SKID_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] RAM_DEPTH = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

  function automatic logic [CRW-1:0] popcount(input logic [READ_LATENCY-1:0] v);
    logic [CRW-1:0] n;
    n = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      n = n + CRW'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [SKID_AW-1:0] skid_next(input logic [SKID_AW-1:0] idx);
    return (idx == SKID_AW'(SKID_DEPTH - 1)) ? '0 : idx + SKID_AW'(1);
  endfunction

  logic [ADDR_WIDTH-1:0]   r_wr_ptr;
  logic [ADDR_WIDTH-1:0]   r_rd_ptr;
  logic [ADDR_WIDTH:0]     r_ram_count;
  logic [READ_LATENCY-1:0] r_inflight;
  logic [DATA_WIDTH-1:0]   r_skid [SKID_DEPTH];
  logic [SKID_AW-1:0]      r_skid_head;
  logic [SKID_AW-1:0]      r_skid_tail;
  logic [SCW-1:0]          r_skid_count;

  logic                    w_push_ready;
  logic                    w_accept;
  logic                    w_issue;
  logic                    w_capture;
  logic                    w_pop_valid;
  logic                    w_pop_fire;
  logic [CRW-1:0]          w_credit_used;
  logic [READ_LATENCY-1:0] w_inflight_nxt;

  // Push side: RAM region has room while fewer than 2**ADDR_WIDTH entries are resident
  assign w_push_ready = r_ram_count < RAM_DEPTH;
  assign w_accept     = fifo.push & w_push_ready;

  // Read credit counts landed and in-flight entries; a pop this cycle does not free credit,
  // which keeps the consumer's pop off the RAM read-enable path.
  assign w_credit_used = CRW'(r_skid_count) + popcount(r_inflight);
  assign w_issue       = (r_ram_count != '0) && (w_credit_used < CRW'(SKID_DEPTH));
  assign w_capture     = r_inflight[READ_LATENCY-1];

  assign w_pop_valid = (r_skid_count != '0);
  assign w_pop_fire  = fifo.pop & w_pop_valid;

  always_comb begin
    w_inflight_nxt    = r_inflight << 1;
    w_inflight_nxt[0] = w_issue;
  end

  // Control state: pointers, RAM occupancy and read-pipeline tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ram_count <= '0;
      r_inflight  <= '0;
    end else begin
      r_inflight <= w_inflight_nxt;
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      case ({w_accept, w_issue})
        2'b10:   r_ram_count <= r_ram_count + (ADDR_WIDTH+1)'(1);
        2'b01:   r_ram_count <= r_ram_count - (ADDR_WIDTH+1)'(1);
        default: r_ram_count <= r_ram_count;
      endcase
    end
  end

  // Skid buffer control: circular head/tail with an explicit count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_skid_head  <= '0;
      r_skid_tail  <= '0;
      r_skid_count <= '0;
    end else begin
      if (w_capture) begin
        r_skid_tail <= skid_next(r_skid_tail);
      end
      if (w_pop_fire) begin
        r_skid_head <= skid_next(r_skid_head);
      end
      case ({w_capture, w_pop_fire})
        2'b10:   r_skid_count <= r_skid_count + SCW'(1);
        2'b01:   r_skid_count <= r_skid_count - SCW'(1);
        default: r_skid_count <= r_skid_count;
      endcase
    end
  end

  // Skid storage is data only and is never cleared
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_skid[r_skid_tail] <= ram_b_rdata;
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    !(w_capture && !w_pop_fire && (r_skid_count == SCW'(SKID_DEPTH))));

`ifdef SDP_RAM_FIFO_COUNT_EN
  logic [ADDR_WIDTH+1:0] r_occupancy;

  // Entries only enter at accept and leave at pop; internal moves keep the total
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occupancy <= '0;
    end else begin
      case ({w_accept, w_pop_fire})
        2'b10:   r_occupancy <= r_occupancy + (ADDR_WIDTH+2)'(1);
        2'b01:   r_occupancy <= r_occupancy - (ADDR_WIDTH+2)'(1);
        default: r_occupancy <= r_occupancy;
      endcase
    end
  end

  assign occupancy = r_occupancy;
`endif

  assign fifo.push_ready = w_push_ready;
  assign fifo.pop_valid  = w_pop_valid;
  assign fifo.pop_data   = r_skid[r_skid_head];

  assign ram_a_en    = w_accept;
  assign ram_a_wbe   = '1;
  assign ram_a_wdata = fifo.push_data;
  assign ram_a_addr  = r_wr_ptr;
  assign ram_b_en    = w_issue;
  assign ram_b_addr  = r_rd_ptr;

endmodule
